// File: rtl/prog_loader128.sv
// prog_loader128
// --------------
// Byte-stream program loader for the 128-bit instruction/data SRAM slave.
// Packs 16 incoming bytes (little-endian, byte 0 in [7:0]) into one 128-bit
// word and issues a single-cycle write per word at consecutive word
// addresses, wrapping modulo 2^ADDR_W. The CPU is held in reset (cpu_hold)
// for the whole load, and a 32-bit byte checksum is reported at completion.
//
// Ports:
//   pll_core_cpuclk  in   clock
//   pad_cpu_rst      in   synchronous active-high reset
//   start            in   one-cycle load request, sampled only in IDLE
//   start_waddr      in   first word address, latched with start
//   word_cnt         in   number of words to load, latched with start
//   in_valid         in   byte-stream valid
//   in_data          in   byte-stream data
//   in_ready         out  byte-stream ready (high only while collecting)
//   prog_wen         out  SRAM write strobe, one cycle per word
//   prog_waddr       out  SRAM word address (holds last written value)
//   prog_wdata       out  SRAM write data (holds last written value)
//   cpu_hold         out  high whenever a load is in progress
//   done             out  one-cycle completion pulse
//   checksum         out  sum of all accepted bytes, modulo 2^32

module prog_loader128 #(
    parameter int ADDR_W = 20
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_waddr,
    input  logic [ADDR_W:0]   word_cnt,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              prog_wen,
    output logic [ADDR_W-1:0] prog_waddr,
    output logic [127:0]      prog_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [31:0]       checksum
);

    localparam int NUM_LANES = 16;
    localparam int LANE_W    = 8;
    localparam int WORD_W    = NUM_LANES * LANE_W;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   COUNT_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_waddr_q, cur_waddr_d;
    logic [ADDR_W:0]     words_left_q, words_left_d;
    logic [3:0]          byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic [31:0]         checksum_q, checksum_d;
    logic [ADDR_W-1:0]   prog_waddr_q, prog_waddr_d;
    logic [WORD_W-1:0]   prog_wdata_q, prog_wdata_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            state_q      <= S_IDLE;
            cur_waddr_q  <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            buf_q        <= '0;
            checksum_q   <= '0;
            prog_waddr_q <= '0;
            prog_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_waddr_q  <= cur_waddr_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            buf_q        <= buf_d;
            checksum_q   <= checksum_d;
            prog_waddr_q <= prog_waddr_d;
            prog_wdata_q <= prog_wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cur_waddr_d  = cur_waddr_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        buf_d        = buf_q;
        checksum_d   = checksum_q;
        prog_waddr_d = prog_waddr_q;
        prog_wdata_d = prog_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_waddr_d  = start_waddr;
                    words_left_d = word_cnt;
                    checksum_d   = '0;
                    byte_idx_d   = '0;
                    buf_d        = '0;
                    state_d      = (word_cnt != '0) ? S_COLLECT : S_DONE;
                end
            end

            S_COLLECT: begin
                // in_ready is high for the whole state, so in_valid alone
                // marks a handshake here.
                if (in_valid) begin
                    buf_d[{byte_idx_q, 3'b000} +: LANE_W] = in_data;
                    byte_idx_d = byte_idx_q + 4'd1;
                    checksum_d = checksum_q + {24'd0, in_data};
                    if (byte_idx_q == 4'd15) begin
                        // Capture the completed word into the output
                        // registers now so prog_waddr/prog_wdata are valid
                        // during the WRITE cycle and hold afterwards.
                        prog_waddr_d = cur_waddr_q;
                        prog_wdata_d = buf_d;
                        state_d      = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                // Address wraps naturally at 2^ADDR_W.
                cur_waddr_d  = cur_waddr_q + ADDR_ONE;
                words_left_d = words_left_q - COUNT_ONE;
                state_d      = (words_left_q == COUNT_ONE) ? S_DONE : S_COLLECT;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state or taken straight from registers
    // ------------------------------------------------------------------
    assign in_ready   = (state_q == S_COLLECT);
    assign prog_wen   = (state_q == S_WRITE);
    assign prog_waddr = prog_waddr_q;
    assign prog_wdata = prog_wdata_q;
    assign cpu_hold   = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_prog_loader128.sv
module tb_prog_loader128;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_waddr;
    logic [ADDR_W:0]   word_cnt;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              prog_wen;
    logic [ADDR_W-1:0] prog_waddr;
    logic [127:0]      prog_wdata;
    logic              cpu_hold;
    logic              done;
    logic [31:0]       checksum;

    prog_loader128 #(.ADDR_W(ADDR_W)) dut (
        .pll_core_cpuclk (clk),
        .pad_cpu_rst     (rst),
        .start           (start),
        .start_waddr     (start_waddr),
        .word_cnt        (word_cnt),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .prog_wen        (prog_wen),
        .prog_waddr      (prog_waddr),
        .prog_wdata      (prog_wdata),
        .cpu_hold        (cpu_hold),
        .done            (done),
        .checksum        (checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [127:0]      d;
    } wr_t;

    wr_t         sb_q[$];
    int          errs   = 0;
    int          checks = 0;
    logic        hold_en = 1'b0;
    logic [31:0] exp_ck = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write monitor / scoreboard pop, sampled on the inactive edge.
    always @(negedge clk) begin
        if (prog_wen) begin
            chk("rdy_in_write", in_ready, 0);
            if (sb_q.size() == 0) begin
                chk("unexpected_wen", prog_waddr, '1);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("waddr", prog_waddr, e.a);
                chk("wdata", prog_wdata, e.d);
            end
        end
        if (hold_en) chk("hold_during_load", cpu_hold, 1);
    end

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int n;
        int gap;
        gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("rdy_timeout", 0, 1);
        step();                      // handshake happens at this edge
        in_valid = 1'b0;
        exp_ck = exp_ck + {24'd0, b};
    endtask

    // Full load: pushes expected writes, drives bytes, checks completion.
    // seq=1 uses bytes 0..15 per word, otherwise random bytes.
    // poke=1 asserts start (with bogus operands) mid-COLLECT.
    task automatic run_load(input logic [ADDR_W-1:0] base, input int nw,
                            input int gapmax, input bit seq, input bit poke);
        logic [7:0]        bytes[16];
        logic [127:0]      w;
        logic [ADDR_W-1:0] a;
        wr_t               e;
        int                n;
        exp_ck      = '0;
        start       = 1'b1;
        start_waddr = base;
        word_cnt    = nw[ADDR_W:0];
        step();
        start = 1'b0;
        chk("hold_after_start", cpu_hold, 1);
        chk("rdy_after_start", in_ready, (nw != 0));
        if (nw == 0) chk("done_zero_cnt", done, 1);
        hold_en = (nw != 0);
        for (int wi = 0; wi < nw; wi++) begin
            a = base + wi[ADDR_W-1:0];
            for (int k = 0; k < 16; k++) begin
                bytes[k] = seq ? k[7:0] : 8'($urandom_range(0, 255));
                w[8*k +: 8] = bytes[k];
            end
            e.a = a;
            e.d = w;
            sb_q.push_back(e);
            for (int k = 0; k < 16; k++) begin
                if (poke && wi == 0 && k == 5) begin
                    start       = 1'b1;
                    start_waddr = ~base;
                    word_cnt    = 21'd7;
                    in_valid    = 1'b1;
                    in_data     = 8'hAA;
                    in_valid    = 1'b0;
                    step();
                    start = 1'b0;
                    chk("poke_still_collect", in_ready, 1);
                    chk("poke_checksum", checksum, exp_ck);
                end
                send_byte(bytes[k], gapmax);
            end
        end
        n = 0;
        while (!done && n < 17) begin
            step();
            n++;
        end
        hold_en = 1'b0;
        chk("done_seen", done, 1);
        chk("done_hold", cpu_hold, 1);
        chk("checksum", checksum, exp_ck);
        step();
        chk("done_pulse_end", done, 0);
        chk("hold_released", cpu_hold, 0);
        chk("checksum_held", checksum, exp_ck);
        chk("sb_empty", sb_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},   in_ready,   0);
        chk({tag, "_wen"},   prog_wen,   0);
        chk({tag, "_waddr"}, prog_waddr, 0);
        chk({tag, "_wdata"}, prog_wdata, 0);
        chk({tag, "_hold"},  cpu_hold,   0);
        chk({tag, "_done"},  done,       0);
        chk({tag, "_ck"},    checksum,   0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_waddr = '0; word_cnt = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) step();
        rst = 1'b0;
        chk_reset_vals("reset");

        // Single word, bytes 0x00..0x0F back to back
        run_load(20'h00010, 1, 0, 1'b1, 1'b0);
        chk("single_ck_const", checksum, 32'h78);

        // Three words with random in_valid gaps
        run_load(20'h0A000, 3, 3, 1'b0, 1'b0);

        // Zero count
        run_load(20'h00123, 0, 0, 1'b0, 1'b0);

        // Address wrap
        run_load(20'hFFFFF, 2, 1, 1'b0, 1'b0);

        // Ignored inputs: in_valid while IDLE, then start mid-COLLECT
        begin
            logic [31:0] ck_before;
            ck_before = checksum;
            in_valid = 1'b1;
            in_data  = 8'h5A;
            repeat (4) begin
                step();
                chk("idle_rdy", in_ready, 0);
                chk("idle_hold", cpu_hold, 0);
                chk("idle_ck", checksum, ck_before);
            end
            in_valid = 1'b0;
        end
        run_load(20'h00200, 1, 0, 1'b0, 1'b1);

        // Mid-load reset after 9 bytes of the second word
        begin
            logic [7:0]   b;
            logic [127:0] w;
            wr_t          e;
            exp_ck      = '0;
            start       = 1'b1;
            start_waddr = 20'h00300;
            word_cnt    = 21'd3;
            step();
            start = 1'b0;
            for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'(8'h40 + k);
            e.a = 20'h00300;
            e.d = w;
            sb_q.push_back(e);
            for (int k = 0; k < 16; k++) send_byte(w[8*k +: 8], 0);
            for (int k = 0; k < 9; k++) begin
                b = 8'(8'hC0 + k);
                send_byte(b, 0);
            end
            chk("pre_rst_ck", checksum, exp_ck);
            rst = 1'b1;
            step();
            chk_reset_vals("midrst");
            rst = 1'b0;
            step();
            chk_reset_vals("midrst_after");
            chk("midrst_sb_empty", sb_q.size(), 0);
        end

        // Full load after the reset
        run_load(20'h00400, 2, 2, 1'b0, 1'b0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
